// File: rtl/galois_sub_three_pipe_pkg.sv
// rtl/galois_sub_three_pipe_pkg.sv - BN254 scalar field constants shared by the field arithmetic blocks
package galois_sub_three_pipe_pkg;

  localparam int BN254_N_BITS = 254;
  localparam logic [BN254_N_BITS-1:0] BN254_PRIME =
    254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;
  // 2p needs one extra bit of magnitude plus a sign bit for the signed correction path
  localparam logic [BN254_N_BITS+1:0] BN254_PRIME_X2 = {1'b0, BN254_PRIME, 1'b0};

endpackage

// File: rtl/galois_sub_reduce.sv
// rtl/galois_sub_reduce.sv - combinational fold of t in [-2p+2, p-1] back into [0, p)
module galois_sub_reduce
  import galois_sub_three_pipe_pkg::*;
#(
  parameter int                  N_BITS        = BN254_N_BITS,
  parameter logic [N_BITS-1:0]   PRIME_MODULUS = BN254_PRIME,
  parameter logic [N_BITS+1:0]   PRIME_X2      = BN254_PRIME_X2
) (
  input  logic signed [N_BITS+1:0] t,
  output logic        [N_BITS-1:0] red
);

  localparam logic signed [N_BITS+1:0] P1 = $signed({2'b00, PRIME_MODULUS});
  localparam logic signed [N_BITS+1:0] P2 = $signed(PRIME_X2);

  logic signed [N_BITS+1:0] r1;
  logic signed [N_BITS+1:0] r2;
  logic signed [N_BITS+1:0] sel;
  logic                     unused_hi;

  always_comb begin
    r1  = t + P1;
    r2  = t + P2;
    sel = r2;
    // first non-negative candidate wins; r2 is non-negative for any in-contract t
    if (!t[N_BITS+1]) begin
      sel = t;
    end else if (!r1[N_BITS+1]) begin
      sel = r1;
    end
  end

  assign red       = sel[N_BITS-1:0];
  assign unused_hi = ^sel[N_BITS+1:N_BITS];

endmodule

// File: rtl/galois_sub_three_pipe.sv
// rtl/galois_sub_three_pipe.sv - two-stage pipelined (num1 - num2 - num3) mod p with valid/ready flow
module galois_sub_three_pipe
  import galois_sub_three_pipe_pkg::*;
#(
  parameter int                N_BITS        = BN254_N_BITS,
  parameter logic [N_BITS-1:0] PRIME_MODULUS = BN254_PRIME
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_BITS-1:0] num1,
  input  logic [N_BITS-1:0] num2,
  input  logic [N_BITS-1:0] num3,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_BITS-1:0] diff
);

  logic signed [N_BITS+1:0] t_in;
  logic signed [N_BITS+1:0] s1_t;
  logic                     s1_valid;
  logic        [N_BITS-1:0] s2_diff;
  logic                     s2_valid;
  logic        [N_BITS-1:0] red;
  logic                     s1_en;
  logic                     s2_en;

  assign t_in = $signed({2'b00, num1}) - $signed({2'b00, num2}) - $signed({2'b00, num3});

  // a stage may load when empty or when the stage downstream is moving
  assign s2_en    = !s2_valid || out_ready;
  assign s1_en    = !s1_valid || s2_en;
  assign in_ready = s1_en && !rst;

  galois_sub_reduce #(
    .N_BITS        (N_BITS),
    .PRIME_MODULUS (PRIME_MODULUS),
    .PRIME_X2      ({1'b0, PRIME_MODULUS, 1'b0})
  ) u_reduce (
    .t   (s1_t),
    .red (red)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_t     <= '0;
      s1_valid <= 1'b0;
      s2_diff  <= '0;
      s2_valid <= 1'b0;
    end else begin
      if (s2_en) begin
        s2_diff  <= red;
        s2_valid <= s1_valid;
      end
      if (s1_en) begin
        s1_t     <= t_in;
        s1_valid <= in_valid;
      end
    end
  end

  assign out_valid = s2_valid;
  assign diff      = s2_diff;

endmodule

// File: tb/tb_galois_sub_three_pipe.sv
// tb/tb_galois_sub_three_pipe.sv - scoreboard bench for galois_sub_three_pipe
module tb_galois_sub_three_pipe;

  localparam int W = 254;
  localparam logic [W-1:0] P = 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;

  typedef struct {
    logic [W-1:0] e;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
    int           cyc;
    bit           lat;
  } item_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] num1, num2, num3;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;

  item_t        exp_q[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           stalls = 0;
  int           bp_start = -100;
  bit           hold = 1'b0;
  bit           prev_stall = 1'b0;
  logic [W-1:0] prev_diff = '0;

  galois_sub_three_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .num1      (num1),
    .num2      (num2),
    .num3      (num3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
    logic [W+3:0] s;
    s = {4'b0, a} + {3'b0, P, 1'b0} - {4'b0, b} - {4'b0, c};
    s = s % {4'b0, P};
    return s[W-1:0];
  endfunction

  function automatic logic [W-1:0] rand_fe();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    r = r % {2'b00, P};
    return r[W-1:0];
  endfunction

  // advance to the next falling edge and drive out_ready from the current schedule
  task automatic step();
    @(negedge clk);
    out_ready = !hold && !(cyc >= bp_start + 3 && cyc <= bp_start + 6);
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                      input logic [W-1:0] e, input bit lat);
    item_t it;
    int    waits = 0;
    in_valid = 1'b1;
    num1 = a; num2 = b; num3 = c;
    #1;
    while (!in_ready && waits <= 50) begin
      stalls++;
      waits++;
      step();
      #1;
    end
    if (!in_ready) begin
      chk("accept_timeout", 1'b0, 1'b1);
    end else begin
      it.e = e; it.a = a; it.b = b; it.c = c; it.cyc = cyc; it.lat = lat;
      exp_q.push_back(it);
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      step();
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  // monitor: samples just before each rising edge
  initial begin
    item_t        it;
    logic [W+3:0] s;
    forever begin
      @(negedge clk);
      #4;
      if (prev_stall && !rst) begin
        chk("stall_valid", out_valid, 1'b1);
        chk("stall_hold", diff, prev_diff);
      end
      if (out_valid && out_ready && !rst) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 1'b1, 1'b0);
        end else begin
          it = exp_q.pop_front();
          chk("diff", diff, it.e);
          s = ({4'b0, diff} + {4'b0, it.b} + {4'b0, it.c}) % {4'b0, P};
          chk("inverse_add", s[W-1:0], it.a);
          if (it.lat) chk("latency", cyc - it.cyc, 2);
        end
      end
      prev_stall = out_valid && !out_ready && !rst;
      prev_diff  = diff;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] a, b, c, x;
    rst = 1'b1; in_valid = 1'b0; num1 = '0; num2 = '0; num3 = '0; out_ready = 1'b0;
    step();
    step();
    #1;
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_diff", diff, '0);
    chk("reset_in_ready", in_ready, 1'b0);
    step();
    rst = 1'b0;
    #1;
    chk("in_ready_after_reset", in_ready, 1'b1);

    // directed arithmetic, back to back with out_ready high
    send(254'd5, 254'd3, 254'd1, 254'd1, 1'b1);
    send(254'd0, 254'd1, 254'd0, P - 254'd1, 1'b1);
    send(254'd0, P - 254'd1, P - 254'd1, 254'd2, 1'b1);
    send(P - 254'd1, P - 254'd2, 254'd1, 254'd0, 1'b1);
    send(254'h1234_5678_9abc, 254'd0, 254'd0, 254'h1234_5678_9abc, 1'b1);
    send(254'd100, 254'd60, 254'd40, 254'd0, 1'b1);
    send(254'd7, 254'd9, 254'd0, P - 254'd2, 1'b1);
    send(254'd10, 254'd3, 254'd4, 254'd3, 1'b1);
    drain();

    // backpressure: out_ready low for relative cycles 3..6
    stalls   = 0;
    bp_start = cyc;
    send(254'd11, 254'd1, 254'd0, 254'd10, 1'b0);
    send(254'd12, 254'd0, 254'd2, 254'd10, 1'b0);
    send(254'd1, 254'd2, 254'd0, P - 254'd1, 1'b0);
    send(254'd50, 254'd25, 254'd25, 254'd0, 1'b0);
    send(254'd0, 254'd0, 254'd3, P - 254'd3, 1'b0);
    send(254'd99, 254'd9, 254'd0, 254'd90, 1'b0);
    chk("bp_stall_cycles", stalls, 4);
    drain();
    bp_start = -100;

    // full throughput with random reduced operands
    stalls = 0;
    for (int i = 0; i < 1000; i++) begin
      a = rand_fe(); b = rand_fe(); c = rand_fe();
      send(a, b, c, model(a, b, c), 1'b1);
    end
    chk("throughput_stalls", stalls, 0);
    drain();

    // reset with two items held in the pipe
    hold = 1'b1;
    step();
    send(254'd20, 254'd5, 254'd5, 254'd10, 1'b0);
    send(254'd30, 254'd5, 254'd5, 254'd20, 1'b0);
    rst = 1'b1;
    in_valid = 1'b1; num1 = 254'd77; num2 = '0; num3 = '0;
    #1;
    chk("in_ready_in_reset", in_ready, 1'b0);
    exp_q.delete();
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    hold = 1'b0;
    #1;
    chk("post_reset_out_valid", out_valid, 1'b0);
    chk("post_reset_diff", diff, '0);
    x = 254'd42;
    send(x, 254'd2, 254'd0, 254'd40, 1'b0);
    drain();

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
